fifo_ctl: RTL and testbench

Sequencing controller for the side-in, broadside-out FIFO datapath used in the bus-interface write/read buffers. It owns the thermometer-coded valid vector and drives the datapath's load and shift controls. It arbitrates push (core side) against pop (bus side) and reports occupancy. It runs the drain sequences: a full flush, and a partial drain on address hit, which uses the datapath's per-entry compare results.

---
 rtl/fifo_ctl_if.sv | 31 +++
 rtl/fifo_ctl.sv | 126 ++++++++++++
 tb/tb_fifo_ctl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ctl_if.sv
// Handshake, drain and datapath-control bundle between the FIFO sequencing controller and its users.
// The slave side is the controller; the master side is the core/bus/datapath environment.
interface fifo_ctl_if #(
   parameter int DEPTH = 4,
   parameter int CNTW  = 3
);
   logic             PUSH_REQ;
   logic             PUSH_ACK;
   logic             POP_REQ;
   logic             POP_ACK;
   logic             FLUSH_REQ;
   logic             FLUSH_DONE;
   logic             HIT_CHK;
   logic [DEPTH-1:0] CTLHITI;
   logic             HIT;
   logic [DEPTH-1:0] CTLLOADO;
   logic             CTLDOSHIFTO;
   logic [CNTW-1:0]  COUNT;
   logic             FULL;
   logic             EMPTY;

   modport master (
      output PUSH_REQ, POP_ACK, FLUSH_REQ, HIT_CHK, CTLHITI,
      input  PUSH_ACK, POP_REQ, FLUSH_DONE, HIT, CTLLOADO, CTLDOSHIFTO, COUNT, FULL, EMPTY
   );

   modport slave (
      input  PUSH_REQ, POP_ACK, FLUSH_REQ, HIT_CHK, CTLHITI,
      output PUSH_ACK, POP_REQ, FLUSH_DONE, HIT, CTLLOADO, CTLDOSHIFTO, COUNT, FULL, EMPTY
   );
endinterface

// File: rtl/fifo_ctl.sv
// Sequencing controller for the side-in, broadside-out FIFO datapath: owns the thermometer
// valid vector, arbitrates push against pop, and runs the flush and hit-drain sequences.
module fifo_ctl #(
   parameter int DEPTH = 4,
   parameter int CNTW  = 3
) (
   input  logic       CLOCKI,
   input  logic       RESET_D1_R,
   fifo_ctl_if.slave  io
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_HITDRN = 2'd2
   } state_e;

   localparam logic [DEPTH-1:0] V_ONE   = {{(DEPTH-1){1'b0}}, 1'b1};
   localparam logic [DEPTH-1:0] V_ZERO  = {DEPTH{1'b0}};
   localparam logic [CNTW-1:0]  C_ONE   = {{(CNTW-1){1'b0}}, 1'b1};
   localparam logic [CNTW-1:0]  C_ZERO  = {CNTW{1'b0}};
   localparam logic [CNTW-1:0]  C_DEPTH = CNTW'(DEPTH);

   state_e           state_q;
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] hmask_q;
   logic [CNTW-1:0]  count_q;
   logic             full_q;
   logic             empty_q;
   logic             flush_done_q;

   logic             pop_s;
   logic             push_s;
   logic             hit_s;
   logic [DEPTH-1:0] valid_d;
   logic [DEPTH-1:0] hmask_d;
   logic [CNTW-1:0]  count_d;

   // Push/pop arbitration, hit detection and next valid/count/mask values.
   always_comb begin
      pop_s   = io.POP_ACK & valid_q[0];
      push_s  = io.PUSH_REQ & (state_q == ST_IDLE) & (~full_q | pop_s);
      hit_s   = (|(io.CTLHITI & valid_q)) & io.HIT_CHK;
      hmask_d = pop_s ? (hmask_q >> 1) : hmask_q;
      valid_d = valid_q;
      count_d = count_q;
      case ({push_s, pop_s})
         2'b10: begin
            valid_d = (valid_q << 1) | V_ONE;
            count_d = count_q + C_ONE;
         end
         2'b01: begin
            valid_d = valid_q >> 1;
            count_d = count_q - C_ONE;
         end
         default: begin
            valid_d = valid_q;
            count_d = count_q;
         end
      endcase
   end

   // Occupancy state, registered status flags and the drain state machine.
   always_ff @(posedge CLOCKI) begin
      if (RESET_D1_R) begin
         state_q      <= ST_IDLE;
         valid_q      <= V_ZERO;
         hmask_q      <= V_ZERO;
         count_q      <= C_ZERO;
         full_q       <= 1'b0;
         empty_q      <= 1'b1;
         flush_done_q <= 1'b0;
      end else begin
         valid_q      <= valid_d;
         count_q      <= count_d;
         full_q       <= (count_d == C_DEPTH);
         empty_q      <= (count_d == C_ZERO);
         flush_done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (io.FLUSH_REQ) begin
                  state_q <= ST_FLUSH;
               end else if (hit_s) begin
                  state_q <= ST_HITDRN;
                  hmask_q <= io.CTLHITI & valid_q;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            // Completion is judged on the settled count, so FLUSH_DONE trails the last pop by a cycle.
            ST_FLUSH: begin
               if (count_q == C_ZERO) begin
                  flush_done_q <= 1'b1;
                  state_q      <= ST_IDLE;
               end else begin
                  state_q <= ST_FLUSH;
               end
            end
            ST_HITDRN: begin
               hmask_q <= hmask_d;
               if (io.FLUSH_REQ) begin
                  state_q <= ST_FLUSH;
               end else if (hmask_d == V_ZERO) begin
                  state_q <= ST_IDLE;
               end else begin
                  state_q <= ST_HITDRN;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign io.PUSH_ACK    = push_s;
   assign io.POP_REQ     = valid_q[0];
   assign io.CTLDOSHIFTO = pop_s;
   assign io.HIT         = hit_s;
   assign io.CTLLOADO    = valid_q;
   assign io.COUNT       = count_q;
   assign io.FULL        = full_q;
   assign io.EMPTY       = empty_q;
   assign io.FLUSH_DONE  = flush_done_q;

endmodule

// File: tb/tb_fifo_ctl.sv
// Bench for fifo_ctl: directed vector rows for the listed corner cases, then random traffic
// compared against an occupancy/mode reference model.
module tb_fifo_ctl;
   localparam int DEPTH = 4;
   localparam int CNTW  = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fifo_ctl_if #(.DEPTH(DEPTH), .CNTW(CNTW)) bus();
   fifo_ctl #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
      .CLOCKI     (clk),
      .RESET_D1_R (rst),
      .io         (bus.slave)
   );

   typedef struct packed {
      logic       ack, shift, hit, popreq, full, empty, done;
      logic [2:0] cnt;
      logic [3:0] load;
   } obs_t;

   typedef struct packed {
      logic       rst, push, pop, flush, hchk;
      logic [3:0] hiti;
      obs_t       exp;
   } vec_t;

   int n_total = 0;
   int n_pass  = 0;

   // Reference model: occupancy, mode (0 idle, 1 flush, 2 hit drain), pops left in a hit drain.
   int m_cnt  = 0;
   int m_mode = 0;
   int m_rem  = 0;
   bit m_done = 1'b0;

   vec_t tbl[17];

   task automatic chk(input string tag, input string fld, input int idx,
                      input logic [3:0] act, input logic [3:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s.%s[%0d]: got %0h, want %0h", tag, fld, idx, act, exp);
      else n_pass++;
   endtask

   function automatic obs_t sample();
      obs_t o;
      o.ack = bus.PUSH_ACK;  o.shift = bus.CTLDOSHIFTO; o.hit = bus.HIT;
      o.popreq = bus.POP_REQ; o.full = bus.FULL; o.empty = bus.EMPTY;
      o.done = bus.FLUSH_DONE; o.cnt = bus.COUNT; o.load = bus.CTLLOADO;
      return o;
   endfunction

   task automatic cmp(input string tag, input int idx, input obs_t a, input obs_t e);
      chk(tag, "PUSH_ACK",    idx, 4'(a.ack),    4'(e.ack));
      chk(tag, "CTLDOSHIFTO", idx, 4'(a.shift),  4'(e.shift));
      chk(tag, "HIT",         idx, 4'(a.hit),    4'(e.hit));
      chk(tag, "POP_REQ",     idx, 4'(a.popreq), 4'(e.popreq));
      chk(tag, "FULL",        idx, 4'(a.full),   4'(e.full));
      chk(tag, "EMPTY",       idx, 4'(a.empty),  4'(e.empty));
      chk(tag, "FLUSH_DONE",  idx, 4'(a.done),   4'(e.done));
      chk(tag, "COUNT",       idx, 4'(a.cnt),    4'(e.cnt));
      chk(tag, "CTLLOADO",    idx, a.load,       e.load);
   endtask

   function automatic logic [3:0] occ_mask(input int n);
      logic [3:0] m;
      m = 4'b0000;
      for (int i = 0; i < n; i++) m[i] = 1'b1;
      return m;
   endfunction

   function automatic obs_t model_expect();
      obs_t e;
      e.shift  = bus.POP_ACK && (m_cnt > 0);
      e.ack    = bus.PUSH_REQ && (m_mode == 0) && ((m_cnt < DEPTH) || e.shift);
      e.hit    = bus.HIT_CHK && ((bus.CTLHITI & occ_mask(m_cnt)) != 4'b0000);
      e.popreq = (m_cnt > 0);
      e.full   = (m_cnt == DEPTH);
      e.empty  = (m_cnt == 0);
      e.done   = m_done;
      e.cnt    = 3'(m_cnt);
      e.load   = occ_mask(m_cnt);
      return e;
   endfunction

   task automatic model_step();
      obs_t e;
      logic [3:0] hits;
      e = model_expect();
      hits = bus.CTLHITI & occ_mask(m_cnt);
      if (rst) begin
         m_cnt = 0; m_mode = 0; m_rem = 0; m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_mode == 0) begin
            if (bus.FLUSH_REQ) m_mode = 1;
            else if (e.hit) begin
               m_mode = 2;
               for (int i = 0; i < DEPTH; i++) if (hits[i]) m_rem = i + 1;
            end
         end else if (m_mode == 1) begin
            if (m_cnt == 0) begin m_done = 1'b1; m_mode = 0; end
         end else begin
            if (e.shift) m_rem--;
            if (bus.FLUSH_REQ) m_mode = 1;
            else if (m_rem == 0) m_mode = 0;
         end
         m_cnt = m_cnt + (e.ack ? 1 : 0) - (e.shift ? 1 : 0);
      end
   endtask

   task automatic drive(input vec_t v);
      rst = v.rst; bus.PUSH_REQ = v.push; bus.POP_ACK = v.pop;
      bus.FLUSH_REQ = v.flush; bus.HIT_CHK = v.hchk; bus.CTLHITI = v.hiti;
   endtask

   task automatic row(input string tag, input int idx, input vec_t v);
      drive(v);
      @(negedge clk);
      cmp(tag, idx, sample(), v.exp);
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      drive(23'd0);
      rst = 1'b1;
      repeat (2) begin
         @(posedge clk);
         model_step();
      end
      #1;
      rst = 1'b0;
   endtask

   initial begin
      // {rst,push,pop,flush,hchk}, CTLHITI, {ack,shift,hit,popreq,full,empty,done}, COUNT, CTLLOADO
      tbl[0]  = {5'b01000, 4'h0, 7'b1000010, 3'd0, 4'h0};
      tbl[1]  = {5'b01000, 4'h0, 7'b1001000, 3'd1, 4'h1};
      tbl[2]  = {5'b01000, 4'h0, 7'b1001000, 3'd2, 4'h3};
      tbl[3]  = {5'b01000, 4'h0, 7'b1001000, 3'd3, 4'h7};
      tbl[4]  = {5'b01000, 4'h0, 7'b0001100, 3'd4, 4'hF};
      tbl[5]  = {5'b01100, 4'h0, 7'b1101100, 3'd4, 4'hF};
      tbl[6]  = {5'b00100, 4'h0, 7'b0101100, 3'd4, 4'hF};
      tbl[7]  = {5'b00100, 4'h0, 7'b0101000, 3'd3, 4'h7};
      tbl[8]  = {5'b00100, 4'h0, 7'b0101000, 3'd2, 4'h3};
      tbl[9]  = {5'b00100, 4'h0, 7'b0101000, 3'd1, 4'h1};
      tbl[10] = {5'b01100, 4'h0, 7'b1000010, 3'd0, 4'h0};
      tbl[11] = {5'b00001, 4'hE, 7'b0001000, 3'd1, 4'h1};
      tbl[12] = {5'b00001, 4'h1, 7'b0011000, 3'd1, 4'h1};
      tbl[13] = {5'b01000, 4'h0, 7'b0001000, 3'd1, 4'h1};
      tbl[14] = {5'b00100, 4'h0, 7'b0101000, 3'd1, 4'h1};
      tbl[15] = {5'b01000, 4'h0, 7'b1000010, 3'd0, 4'h0};
      tbl[16] = {5'b00000, 4'h0, 7'b0001000, 3'd1, 4'h1};

      do_reset();
      for (int i = 0; i < 17; i++) row("tbl", i, tbl[i]);

      // Flush from COUNT=3 with pops every cycle, then hit drain from full, then reset mid-drain.
      do_reset();
      row("flush", 0, {5'b01000, 4'h0, 7'b1000010, 3'd0, 4'h0});
      row("flush", 1, {5'b01000, 4'h0, 7'b1001000, 3'd1, 4'h1});
      row("flush", 2, {5'b01000, 4'h0, 7'b1001000, 3'd2, 4'h3});
      row("flush", 3, {5'b00110, 4'h0, 7'b0101000, 3'd3, 4'h7});
      row("flush", 4, {5'b01110, 4'h0, 7'b0101000, 3'd2, 4'h3});
      row("flush", 5, {5'b01110, 4'h0, 7'b0101000, 3'd1, 4'h1});
      row("flush", 6, {5'b01010, 4'h0, 7'b0000010, 3'd0, 4'h0});
      row("flush", 7, {5'b01000, 4'h0, 7'b1000011, 3'd0, 4'h0});
      row("flush", 8, {5'b00000, 4'h0, 7'b0001000, 3'd1, 4'h1});
      row("hitdrn", 0, {5'b01000, 4'h0, 7'b1001000, 3'd1, 4'h1});
      row("hitdrn", 1, {5'b01001, 4'h8, 7'b1001000, 3'd2, 4'h3});
      row("hitdrn", 2, {5'b01001, 4'h8, 7'b1001000, 3'd3, 4'h7});
      row("hitdrn", 3, {5'b00001, 4'h6, 7'b0011100, 3'd4, 4'hF});
      row("hitdrn", 4, {5'b01101, 4'h6, 7'b0111100, 3'd4, 4'hF});
      row("hitdrn", 5, {5'b00100, 4'h0, 7'b0101000, 3'd3, 4'h7});
      row("hitdrn", 6, {5'b00100, 4'h0, 7'b0101000, 3'd2, 4'h3});
      row("hitdrn", 7, {5'b01000, 4'h0, 7'b1001000, 3'd1, 4'h1});
      row("rstdrn", 0, {5'b00001, 4'h3, 7'b0011000, 3'd2, 4'h3});
      row("rstdrn", 1, {5'b11000, 4'h0, 7'b0001000, 3'd2, 4'h3});
      row("rstdrn", 2, {5'b01000, 4'h0, 7'b1000010, 3'd0, 4'h0});
      row("rstdrn", 3, {5'b00000, 4'h0, 7'b0001000, 3'd1, 4'h1});

      do_reset();
      for (int c = 0; c < 1500; c++) begin
         rst           = ($urandom_range(0, 249) == 0);
         bus.PUSH_REQ  = 1'($urandom_range(0, 1));
         bus.POP_ACK   = (m_cnt > 0) && ($urandom_range(0, 2) != 0);
         bus.FLUSH_REQ = (m_mode == 1) || ($urandom_range(0, 39) == 0);
         bus.HIT_CHK   = ($urandom_range(0, 3) == 0);
         bus.CTLHITI   = 4'($urandom_range(0, 15));
         @(negedge clk);
         cmp("rand", c, sample(), model_expect());
         @(posedge clk);
         model_step();
         #1;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
